// File: rtl/seq_mult_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_mult_core : shift-add sequential multiplier, signed/unsigned, DW-bit ops
// rev 1.0 - initial release
// ----------------------------------------------------------------------------
module seq_mult_core #(
  parameter int DW = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_signed,
  input  logic [DW-1:0]     i_mltnd,
  input  logic [DW-1:0]     i_mlter,
  output logic              o_busy,
  output logic              o_done,
  output logic [2*DW-1:0]   o_product,
  output logic              o_sign
);

  localparam int            CW       = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2*DW-1:0]  mcand_q, mcand_d;
  logic [DW-1:0]    mplier_q, mplier_d;
  logic [2*DW-1:0]  acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [2*DW-1:0]  product_q, product_d;
  logic             sign_q, sign_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Unsigned negation keeps -2^(DW-1) as magnitude 2^(DW-1) in DW bits.
  logic [DW-1:0]    mag_a, mag_b;
  assign mag_a = (i_signed && i_mltnd[DW-1]) ? -i_mltnd : i_mltnd;
  assign mag_b = (i_signed && i_mlter[DW-1]) ? -i_mlter : i_mlter;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    sign_d    = sign_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          mcand_d  = {{DW{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = i_signed & (i_mltnd[DW-1] ^ i_mlter[DW-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        // A zero magnitude never turns into a negative result.
        if (neg_q && (acc_q != '0)) begin
          product_d = -acc_q;
          sign_d    = 1'b1;
        end else begin
          product_d = acc_q;
          sign_d    = 1'b0;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      sign_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      sign_q    <= sign_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_product = product_q;
  assign o_sign    = sign_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_core.sv
`default_nettype none
// Bench for seq_mult_core: DW=8 instance checked every cycle against a
// behavioural model, plus a DW=16 instance for wide/back-to-back cases.
module tb_seq_mult_core;

  localparam int DW  = 8;
  localparam int DW2 = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic            start8 = 1'b0, sgn8 = 1'b0;
  logic [DW-1:0]   a8 = '0, b8 = '0;
  logic            busy8, done8, sign8;
  logic [2*DW-1:0] prod8;

  logic             start16 = 1'b0, sgn16 = 1'b0;
  logic [DW2-1:0]   a16 = '0, b16 = '0;
  logic             busy16, done16, sign16;
  logic [2*DW2-1:0] prod16;

  seq_mult_core #(.DW(DW)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_signed(sgn8),
    .i_mltnd(a8), .i_mlter(b8),
    .o_busy(busy8), .o_done(done8), .o_product(prod8), .o_sign(sign8)
  );

  seq_mult_core #(.DW(DW2)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_start(start16), .i_signed(sgn16),
    .i_mltnd(a16), .i_mlter(b16),
    .o_busy(busy16), .o_done(done16), .o_product(prod16), .o_sign(sign16)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference result from plain arithmetic: {sign, product}.
  function automatic logic [2*DW:0] ref8(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic s);
    logic signed [2*DW-1:0] p;
    logic [2*DW-1:0]        u;
    if (s) begin
      p = $signed(a) * $signed(b);
      return {p[2*DW-1], p};
    end
    u = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    return {1'b0, u};
  endfunction

  // Model: an accepted request keeps the core busy for DW+2 cycles; the
  // result appears together with the done cycle (the last busy cycle).
  int              m_rem   = 0;
  logic [2*DW-1:0] m_prod  = '0, m_pend = '0;
  logic            m_sign  = 1'b0, m_psign = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem  <= 0;
      m_prod <= '0;
      m_sign <= 1'b0;
    end else if (m_rem == 0) begin
      if (start8) begin
        {m_psign, m_pend} <= ref8(a8, b8, sgn8);
        m_rem <= DW + 2;
      end
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 2) begin
        m_prod <= m_pend;
        m_sign <= m_psign;
      end
    end
  end

  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy",    64'(busy8), 64'(m_rem != 0));
      chk("done",    64'(done8), 64'(m_rem == 1));
      chk("product", 64'(prod8), 64'(m_prod));
      chk("sign",    64'(sign8), 64'(m_sign));
    end
  end

  task automatic run8(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s,
                      input logic [2*DW-1:0] ep, input logic es, input string name);
    int n;
    @(negedge clk);
    a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 1;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(DW + 2));
    chk({name, "_product"}, 64'(prod8), 64'(ep));
    chk({name, "_sign"},    64'(sign8), 64'(es));
    @(negedge clk);
  endtask

  initial begin
    int n;
    int dn;

    #1 rst = 1'b1;
    #2;
    chk("rst_busy",    64'(busy8), 64'd0);
    chk("rst_done",    64'(done8), 64'd0);
    chk("rst_product", 64'(prod8), 64'd0);
    chk("rst_sign",    64'(sign8), 64'd0);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run8(8'h07, 8'hFD, 1'b1, 16'hFFEB, 1'b1, "t1_7xm3");
    run8(8'h80, 8'h80, 1'b1, 16'h4000, 1'b0, "t2_minxmin");
    run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0, "t2_ffxff_u");
    run8(8'h00, 8'hFB, 1'b1, 16'h0000, 1'b0, "t3_zero");
    run8(8'h01, 8'hFF, 1'b1, 16'hFFFF, 1'b1, "t3_1xm1");

    // Second request and operand changes while busy must be ignored.
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd6; sgn8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'hAA; sgn8 = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done8) dn++;
    end
    chk("t4_done_count", 64'(dn),    64'd1);
    chk("t4_product",    64'(prod8), 64'd30);
    chk("t4_sign",       64'(sign8), 64'd0);

    // Asynchronous reset in the middle of CALC cycle 4.
    a8 = 8'd100; b8 = 8'd3; sgn8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_busy",    64'(busy8), 64'd0);
    chk("t5_rst_done",    64'(done8), 64'd0);
    chk("t5_rst_product", 64'(prod8), 64'd0);
    chk("t5_rst_sign",    64'(sign8), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8) dn++;
    end
    chk("t5_no_done", 64'(dn), 64'd0);
    run8(8'd3, 8'd4, 1'b0, 16'd12, 1'b0, "t5_3x4");

    // Wide instance with start held high continuously.
    @(negedge clk);
    a16 = 16'h8000; b16 = 16'h7FFF; sgn16 = 1'b1; start16 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done16 && n < 60);
    chk("t6_latency", 64'(n),      64'(DW2 + 2));
    chk("t6_product", 64'(prod16), 64'h0000_0000_C000_8000);
    chk("t6_sign",    64'(sign16), 64'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done16 && n < 60);
    chk("t6_period",   64'(n),      64'(DW2 + 3));
    chk("t6_product2", 64'(prod16), 64'h0000_0000_C000_8000);
    start16 = 1'b0;

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
